// File: rtl/acq_sequencer_if.sv
// acq_sequencer_if
// Command bus from the acquisition sequencer to the channel instruction
// decoder.
//   inst_reg : command code (0 idle, 1 reset, 2 readout, 3 start)
//   cs       : command strobe, high only while inst_reg holds a stable code
//
// Protocol: the sequencer presents a code for one setup cycle with cs low.
// It then raises cs for the pulse width and drops cs for one hold cycle
// before the code changes. The decoder may therefore latch inst_reg on any
// cycle where cs is high. There is no back-pressure; the decoder always
// accepts a command.
interface acq_sequencer_if;
    logic [1:0] inst_reg;
    logic       cs;

    modport master (output inst_reg, output cs);
    modport slave  (input  inst_reg, input  cs);
endinterface

// File: rtl/acq_sequencer.sv
// acq_sequencer
// Sequences one acquisition cycle for the channel instruction decoder. The
// sequence is: reset command, start command, wait for trigger, readout
// command, wait for readout completion. It can optionally re-arm itself for
// a programmed number of events. A trigger timeout and an abort input both
// return the sequencer to IDLE.
//
// Ports
//   clk, rstn      : clock, synchronous active-low reset
//   arm            : start request (IDLE only)
//   abort          : terminate the current acquisition cycle
//   auto_rearm     : re-arm after each readout (sampled at arm)
//   n_events       : events per run when re-arming, 0 = unlimited (sampled at arm)
//   timeout_cyc    : trigger wait limit in cycles, 0 = none (sampled at arm)
//   trig           : trigger, synchronous to clk
//   readout_done   : single-cycle readout completion pulse
//   dec            : command bus to the decoder (inst_reg, cs)
//   busy           : high outside IDLE
//   event_cnt      : completed readouts since last accepted arm, saturating
//   timeout_flag   : sticky trigger-timeout indication, cleared by arm
//   done           : one-cycle pulse on every return to IDLE
//   dbg_state      : current FSM state for observation
//
// All outputs are registered. Each one is computed from the next-state logic
// and captured on the same edge as the state itself.
module acq_sequencer #(
    parameter int PULSE_W = 4,
    parameter int TMO_W   = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 auto_rearm,
    input  logic [7:0]           n_events,
    input  logic [TMO_W-1:0]     timeout_cyc,
    input  logic                 trig,
    input  logic                 readout_done,
    acq_sequencer_if.master      dec,
    output logic                 busy,
    output logic [7:0]           event_cnt,
    output logic                 timeout_flag,
    output logic                 done,
    output logic [2:0]           dbg_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CMD_RST   = 3'd1;
    localparam logic [2:0] S_CMD_START = 3'd2;
    localparam logic [2:0] S_WAIT_TRIG = 3'd3;
    localparam logic [2:0] S_CMD_RO    = 3'd4;
    localparam logic [2:0] S_WAIT_RO   = 3'd5;

    // The phase counter runs 0 (setup), 1..PULSE_W (strobe), PULSE_W+1 (hold).
    localparam int            CW      = $clog2(PULSE_W + 2);
    localparam logic [CW-1:0] PH_HOLD = CW'(PULSE_W + 1);

    logic [2:0]       state, state_n;
    logic [CW-1:0]    ph, ph_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic             abort_pend, pend_n;
    logic [7:0]       evt_n, evt_inc;
    logic             tf_n;
    logic             arm_ok;
    logic             auto_q;
    logic [7:0]       n_ev_q;
    logic [TMO_W-1:0] tmo_q;

    assign evt_inc   = (event_cnt == 8'hFF) ? 8'hFF : event_cnt + 8'd1;
    assign dbg_state = state;

    function automatic logic is_cmd(input logic [2:0] s);
        return (s == S_CMD_RST) || (s == S_CMD_START) || (s == S_CMD_RO);
    endfunction

    function automatic logic [1:0] code_of(input logic [2:0] s);
        case (s)
            S_CMD_RST:   return 2'd1;
            S_CMD_RO:    return 2'd2;
            S_CMD_START: return 2'd3;
            default:     return 2'd0;
        endcase
    endfunction

    always_comb begin
        state_n = state;
        ph_n    = ph;
        tmo_n   = tmo_cnt;
        pend_n  = abort_pend;
        evt_n   = event_cnt;
        tf_n    = timeout_flag;
        arm_ok  = 1'b0;

        case (state)
            S_IDLE: begin
                // arm together with abort is refused outright
                if (arm && !abort) begin
                    state_n = S_CMD_RST;
                    ph_n    = '0;
                    evt_n   = 8'd0;
                    tf_n    = 1'b0;
                    arm_ok  = 1'b1;
                end
            end

            S_CMD_RST, S_CMD_START, S_CMD_RO: begin
                if (ph == PH_HOLD) begin
                    ph_n = '0;
                    if (abort_pend || abort) begin
                        state_n = S_IDLE;
                    end else if (state == S_CMD_RST) begin
                        state_n = S_CMD_START;
                    end else if (state == S_CMD_START) begin
                        state_n = S_WAIT_TRIG;
                        tmo_n   = '0;
                    end else begin
                        state_n = S_WAIT_RO;
                    end
                end else begin
                    // An abort never truncates a strobe: remember it until hold.
                    ph_n = ph + 1'b1;
                    if (abort) pend_n = 1'b1;
                end
            end

            S_WAIT_TRIG: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (trig) begin
                    // A trigger in the last allowed cycle still wins over timeout.
                    state_n = S_CMD_RO;
                    ph_n    = '0;
                end else if ((tmo_q != '0) && (tmo_cnt == tmo_q - TMO_W'(1))) begin
                    state_n = S_IDLE;
                    tf_n    = 1'b1;
                end else begin
                    tmo_n = tmo_cnt + TMO_W'(1);
                end
            end

            S_WAIT_RO: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else if (readout_done) begin
                    evt_n = evt_inc;
                    if (auto_q && ((n_ev_q == 8'd0) || (evt_inc < n_ev_q))) begin
                        state_n = S_CMD_RST;
                        ph_n    = '0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
                ph_n    = '0;
            end
        endcase

        if (state_n == S_IDLE) pend_n = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            ph           <= '0;
            tmo_cnt      <= '0;
            abort_pend   <= 1'b0;
            auto_q       <= 1'b0;
            n_ev_q       <= 8'd0;
            tmo_q        <= '0;
            event_cnt    <= 8'd0;
            timeout_flag <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dec.inst_reg <= 2'd0;
            dec.cs       <= 1'b0;
        end else begin
            state        <= state_n;
            ph           <= ph_n;
            tmo_cnt      <= tmo_n;
            abort_pend   <= pend_n;
            event_cnt    <= evt_n;
            timeout_flag <= tf_n;
            busy         <= (state_n != S_IDLE);
            done         <= (state != S_IDLE) && (state_n == S_IDLE);
            dec.inst_reg <= code_of(state_n);
            // The strobe is high only strictly inside the setup/hold window,
            // so it never moves on the same edge as inst_reg.
            dec.cs       <= is_cmd(state_n) && (ph_n != '0) && (ph_n != PH_HOLD);
            if (arm_ok) begin
                auto_q <= auto_rearm;
                n_ev_q <= n_events;
                tmo_q  <= timeout_cyc;
            end
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// Testbench for acq_sequencer. Each scenario builds a cycle-indexed plan of
// stimulus and expected outputs from the command timing rules. A single
// compare process checks every output on every cycle of the scenario.
// Literal pins after selected scenarios tie the plan to hand-derived cycles.
module tb_acq_sequencer;
    localparam int P  = 4;       // PULSE_W
    localparam int L  = P + 2;   // cycles per command phase
    localparam int TW = 16;
    localparam int N  = 128;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstn;

    logic          arm, abort, auto_rearm, trig, readout_done;
    logic [7:0]    n_events;
    logic [TW-1:0] timeout_cyc;
    logic          busy, timeout_flag, done;
    logic [7:0]    event_cnt;
    logic [2:0]    dbg_state;

    acq_sequencer_if dec();

    acq_sequencer #(.PULSE_W(P), .TMO_W(TW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .arm          (arm),
        .abort        (abort),
        .auto_rearm   (auto_rearm),
        .n_events     (n_events),
        .timeout_cyc  (timeout_cyc),
        .trig         (trig),
        .readout_done (readout_done),
        .dec          (dec),
        .busy         (busy),
        .event_cnt    (event_cnt),
        .timeout_flag (timeout_flag),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    // plan: stimulus and expected outputs per cycle
    logic       s_arm[N], s_abort[N], s_trig[N], s_rd[N], s_rst[N];
    logic [1:0] e_inst[N];
    logic       e_cs[N], e_busy[N], e_done[N], e_tf[N];
    logic [7:0] e_evt[N];
    // observed outputs, used by the literal pins
    logic [1:0] a_inst[N];
    logic       a_cs[N], a_busy[N], a_done[N], a_tf[N];
    logic [7:0] a_evt[N];

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    bit    running = 1'b0;
    string scen   = "none";
    int    m_evt;

    task automatic chk(input string name, input int c, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s %s cycle %0d: got %0h expected %0h", scen, name, c, got, exp);
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) begin
            s_arm[i] = 0; s_abort[i] = 0; s_trig[i] = 0; s_rd[i] = 0; s_rst[i] = 0;
            e_inst[i] = 0; e_cs[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_tf[i] = 0;
            e_evt[i] = 0;
        end
        m_evt = 0;
    endtask

    // one full command window starting with its setup cycle at t
    task automatic cmd(input int t, input logic [1:0] code);
        for (int i = 0; i < L; i++) e_inst[t+i] = code;
        for (int i = 1; i <= P; i++) e_cs[t+i] = 1'b1;
    endtask

    task automatic busy_rng(input int a, input int b);
        for (int i = a; i <= b; i++) e_busy[i] = 1'b1;
    endtask

    task automatic evt_from(input int t, input int v);
        for (int i = t; i < N; i++) e_evt[i] = 8'(v);
    endtask

    task automatic tf_from(input int t, input logic v);
        for (int i = t; i < N; i++) e_tf[i] = v;
    endtask

    // One event: reset and start commands from t, trigger dt cycles into the
    // trigger wait, readout_done dr cycles into the readout wait.
    // tn is the cycle after readout_done.
    task automatic plan_event(input int t, input int dt, input int dr, output int tn);
        int wt, k, wr, m;
        cmd(t, 2'd1);
        cmd(t + L, 2'd3);
        wt = t + 2 * L;
        k  = wt + dt;
        s_trig[k] = 1'b1;
        cmd(k + 1, 2'd2);
        wr = k + 1 + L;
        m  = wr + dr;
        s_rd[m] = 1'b1;
        m_evt++;
        evt_from(m + 1, m_evt);
        tn = m + 1;
    endtask

    // driver: reset, then apply the plan cycle by cycle
    task automatic run(input int len);
        rstn = 0; arm = 0; abort = 0; trig = 0; readout_done = 0;
        repeat (3) @(posedge clk);
        running = 1'b1;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            cyc          = c;
            rstn         = !s_rst[c];
            arm          = s_arm[c];
            abort        = s_abort[c];
            trig         = s_trig[c];
            readout_done = s_rd[c];
        end
        @(negedge clk);
        running = 1'b0;
        arm = 0; abort = 0; trig = 0; readout_done = 0;
    endtask

    // scoreboard: every output, every planned cycle
    always @(negedge clk) begin
        #1;
        if (running) begin
            a_inst[cyc] = dec.inst_reg;
            a_cs[cyc]   = dec.cs;
            a_busy[cyc] = busy;
            a_done[cyc] = done;
            a_evt[cyc]  = event_cnt;
            a_tf[cyc]   = timeout_flag;
            chk("inst_reg",     cyc, 8'(dec.inst_reg), 8'(e_inst[cyc]));
            chk("cs",           cyc, 8'(dec.cs),       8'(e_cs[cyc]));
            chk("busy",         cyc, 8'(busy),         8'(e_busy[cyc]));
            chk("done",         cyc, 8'(done),         8'(e_done[cyc]));
            chk("event_cnt",    cyc, event_cnt,        e_evt[cyc]);
            chk("timeout_flag", cyc, 8'(timeout_flag), 8'(e_tf[cyc]));
        end
    end

    initial begin
        int t;
        rstn = 0; arm = 0; abort = 0; trig = 0; readout_done = 0;
        auto_rearm = 0; n_events = 0; timeout_cyc = 0;

        // single shot
        scen = "single"; clear_plan();
        auto_rearm = 0; n_events = 0; timeout_cyc = 0;
        s_arm[0] = 1; plan_event(1, 7, 3, t);
        e_done[t] = 1; busy_rng(1, t - 1);
        run(40);
        chk("pin_cs2",    2,  8'(a_cs[2]),    8'd1);
        chk("pin_cs5",    5,  8'(a_cs[5]),    8'd1);
        chk("pin_cs6",    6,  8'(a_cs[6]),    8'd0);
        chk("pin_inst8",  8,  8'(a_inst[8]),  8'd3);
        chk("pin_inst22", 22, 8'(a_inst[22]), 8'd2);
        chk("pin_cs25",   25, 8'(a_cs[25]),   8'd1);
        chk("pin_busy30", 30, 8'(a_busy[30]), 8'd1);
        chk("pin_done31", 31, 8'(a_done[31]), 8'd1);
        chk("pin_evt31",  31, a_evt[31],      8'd1);

        // auto re-arm, three events, trigger/readout at boundary offsets
        scen = "rearm3"; clear_plan();
        auto_rearm = 1; n_events = 3; timeout_cyc = 0;
        s_arm[0] = 1; t = 1;
        plan_event(t, 2, 2, t);
        plan_event(t, 0, 0, t);
        plan_event(t, 3, 3, t);
        e_done[t] = 1; busy_rng(1, t - 1);
        run(80);
        chk("pin_done71", 71, 8'(a_done[71]), 8'd1);
        chk("pin_evt71",  71, a_evt[71],      8'd3);

        // unlimited re-arm, stopped by abort while waiting for trigger
        scen = "unlimited"; clear_plan();
        auto_rearm = 1; n_events = 0; timeout_cyc = 0;
        s_arm[0] = 1; t = 1;
        plan_event(t, 2, 2, t);
        plan_event(t, 2, 2, t);
        cmd(t, 2'd1); cmd(t + L, 2'd3);
        s_abort[t + 2*L + 3] = 1; e_done[t + 2*L + 4] = 1;
        busy_rng(1, t + 2*L + 3);
        run(75);

        // trigger timeout, then trigger in the final timeout cycle
        scen = "timeout"; clear_plan();
        auto_rearm = 0; n_events = 0; timeout_cyc = 3;
        s_arm[0] = 1; cmd(1, 2'd1); cmd(7, 2'd3);
        e_done[16] = 1; tf_from(16, 1'b1); busy_rng(1, 15);
        s_arm[20] = 1; tf_from(21, 1'b0);
        plan_event(21, 2, 1, t);
        e_done[t] = 1; busy_rng(21, t - 1);
        run(55);
        chk("pin_tf16",   16, 8'(a_tf[16]),   8'd1);
        chk("pin_done16", 16, 8'(a_done[16]), 8'd1);
        chk("pin_inst36", 36, 8'(a_inst[36]), 8'd2);

        // ignored inputs, then arm together with abort in IDLE
        scen = "ignored"; clear_plan();
        auto_rearm = 0; n_events = 0; timeout_cyc = 0;
        s_arm[0] = 1; s_trig[3] = 1; s_arm[10] = 1; s_rd[15] = 1;
        plan_event(1, 7, 3, t);
        e_done[t] = 1; busy_rng(1, t - 1);
        s_arm[35] = 1; s_abort[35] = 1;
        run(45);

        // abort mid start-pulse, then abort while waiting for readout
        scen = "abort"; clear_plan();
        auto_rearm = 0; n_events = 0; timeout_cyc = 0;
        s_arm[0] = 1; cmd(1, 2'd1); cmd(7, 2'd3);
        s_abort[9] = 1; e_done[13] = 1; busy_rng(1, 12);
        s_arm[20] = 1; cmd(21, 2'd1); cmd(27, 2'd3);
        s_trig[34] = 1; cmd(35, 2'd2);
        s_abort[43] = 1; e_done[44] = 1; busy_rng(21, 43);
        run(55);
        chk("pin_cs11",   11, 8'(a_cs[11]),   8'd1);
        chk("pin_inst13", 13, 8'(a_inst[13]), 8'd0);
        chk("pin_done13", 13, 8'(a_done[13]), 8'd1);

        // reset during the readout strobe, then a normal restart
        scen = "midreset"; clear_plan();
        auto_rearm = 0; n_events = 0; timeout_cyc = 0;
        s_arm[0] = 1; cmd(1, 2'd1); cmd(7, 2'd3);
        s_trig[14] = 1; cmd(15, 2'd2);
        for (int i = 18; i <= 20; i++) begin e_inst[i] = 0; e_cs[i] = 0; end
        s_rst[17] = 1; busy_rng(1, 17);
        s_arm[22] = 1; plan_event(23, 1, 1, t);
        e_done[t] = 1; busy_rng(23, t - 1);
        run(55);
        chk("pin_cs17",   17, 8'(a_cs[17]),   8'd1);
        chk("pin_cs18",   18, 8'(a_cs[18]),   8'd0);
        chk("pin_busy18", 18, 8'(a_busy[18]), 8'd0);
        chk("pin_done45", 45, 8'(a_done[45]), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
